// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// write-port indices and a helper for locating a port's slice in packed buses.
package reg_file_mp_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NRP    = 2;

    typedef enum logic {
        WP0 = 1'b0,
        WP1 = 1'b1
    } wrPort_e;

    // Low bit of a write port's field inside a bus packed per write port
    function automatic int portLsb(input wrPort_e port, input int width);
        return int'(port) * width;
    endfunction

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by an issue and
// cleared by an effective write, with a same-cycle write masking the read view.
module reg_scoreboard
    import reg_file_mp_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NRP     = DEF_NRP,
    parameter int ZERO_R0 = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    input  logic                  wrEff0,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic                  wrEff1,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [NRP*ADDR_W-1:0] rd_addr,
    output logic [NRP-1:0]        rd_busy
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam bit ZERO_EN = (ZERO_R0 != 0);

    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busyNext;
    logic              issOk;
    logic [ADDR_W-1:0] rdA;

    // Next busy state: writes clear first so a same-cycle issue (new producer) wins
    always_comb begin
        issOk    = iss_en && !(ZERO_EN && (iss_addr == '0));
        busyNext = busy;
        if (wrEff0) busyNext[waddr0] = 1'b0;
        if (wrEff1) busyNext[waddr1] = 1'b0;
        if (issOk)  busyNext[iss_addr] = 1'b1;
    end

    // Busy bit register, cleared by reset so issues in a reset cycle are lost
    always_ff @(posedge clk) begin
        if (reset) busy <= '0;
        else       busy <= busyNext;
    end

    // Per-port busy view; a write landing this cycle already resolves the hazard
    always_comb begin
        rd_busy = '0;
        rdA     = '0;
        for (int k = 0; k < NRP; k++) begin
            rdA        = rd_addr[k*ADDR_W +: ADDR_W];
            rd_busy[k] = busy[rdA] && !((wrEff0 && (waddr0 == rdA)) ||
                                        (wrEff1 && (waddr1 == rdA)));
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port flop-based register file: NRP combinational read ports with
// write-through bypass, two write ports (port 1 wins on collision), a
// pending-write scoreboard and a one-cycle registered commit log.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NRP     = DEF_NRP,
    parameter int ZERO_R0 = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRP*ADDR_W-1:0] rd_addr,
    output logic [NRP*DATA_W-1:0] rd_data,
    output logic [NRP-1:0]        rd_busy,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic [1:0]            log_vld,
    output logic [2*ADDR_W-1:0]   log_addr,
    output logic [2*DATA_W-1:0]   log_data
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam bit ZERO_EN = (ZERO_R0 != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wrCand0;
    logic              wrCand1;
    logic              wrEff0;
    logic              wrEff1;
    logic [ADDR_W-1:0] rdA;
    logic [DATA_W-1:0] rdW;

    // Effective writes: drop writes to r0 when hardwired, drop port 0 on collision
    always_comb begin
        wrCand0 = we0 && !(ZERO_EN && (waddr0 == '0));
        wrCand1 = we1 && !(ZERO_EN && (waddr1 == '0));
        wrEff1  = wrCand1;
        wrEff0  = wrCand0 && !(wrCand1 && (waddr0 == waddr1));
    end

    // Register storage; effective writes never target the same entry
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (wrEff0) regs[waddr0] <= wdata0;
            if (wrEff1) regs[waddr1] <= wdata1;
        end
    end

    // Read ports with write-through bypass; port 1 checked last so it takes precedence
    always_comb begin
        rd_data = '0;
        rdA     = '0;
        rdW     = '0;
        for (int k = 0; k < NRP; k++) begin
            rdA = rd_addr[k*ADDR_W +: ADDR_W];
            rdW = regs[rdA];
            if (wrEff0 && (waddr0 == rdA)) rdW = wdata0;
            if (wrEff1 && (waddr1 == rdA)) rdW = wdata1;
            if (ZERO_EN && (rdA == '0))    rdW = '0;
            rd_data[k*DATA_W +: DATA_W] = rdW;
        end
    end

    // Commit log: one-cycle valid pulse per effective write, address/data held until next commit
    always_ff @(posedge clk) begin
        if (reset) begin
            log_vld  <= '0;
            log_addr <= '0;
            log_data <= '0;
        end else begin
            log_vld <= {wrEff1, wrEff0};
            if (wrEff0) begin
                log_addr[portLsb(WP0, ADDR_W) +: ADDR_W] <= waddr0;
                log_data[portLsb(WP0, DATA_W) +: DATA_W] <= wdata0;
            end
            if (wrEff1) begin
                log_addr[portLsb(WP1, ADDR_W) +: ADDR_W] <= waddr1;
                log_data[portLsb(WP1, DATA_W) +: DATA_W] <= wdata1;
            end
        end
    end

    reg_scoreboard #(
        .ADDR_W  (ADDR_W),
        .NRP     (NRP),
        .ZERO_R0 (ZERO_R0)
    ) scoreboard (
        .clk      (clk),
        .reset    (reset),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wrEff0   (wrEff0),
        .waddr0   (waddr0),
        .wrEff1   (wrEff1),
        .waddr1   (waddr1),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: dutA has four read ports with r0 hardwired
// to zero, dutB has two read ports with r0 as an ordinary register. Both share
// clock, reset, write, issue and (low) read-address stimulus.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [4*AW-1:0] rdAddr;
    logic [4*DW-1:0] rdDataA;
    logic [3:0]      rdBusyA;
    logic [2*DW-1:0] rdDataB;
    logic [1:0]      rdBusyB;
    logic            we0, we1, issEn;
    logic [AW-1:0]   waddr0, waddr1, issAddr;
    logic [DW-1:0]   wdata0, wdata1;
    logic [1:0]      logVldA, logVldB;
    logic [2*AW-1:0] logAddrA, logAddrB;
    logic [2*DW-1:0] logDataA, logDataB;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NRP(4), .ZERO_R0(1)) dutA (
        .clk(clk), .reset(reset),
        .rd_addr(rdAddr), .rd_data(rdDataA), .rd_busy(rdBusyA),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .iss_en(issEn), .iss_addr(issAddr),
        .log_vld(logVldA), .log_addr(logAddrA), .log_data(logDataA)
    );

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NRP(2), .ZERO_R0(0)) dutB (
        .clk(clk), .reset(reset),
        .rd_addr(rdAddr[2*AW-1:0]), .rd_data(rdDataB), .rd_busy(rdBusyB),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .iss_en(issEn), .iss_addr(issAddr),
        .log_vld(logVldB), .log_addr(logAddrB), .log_data(logDataB)
    );

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        issEn = 1'b0; issAddr = '0;
    endtask

    task automatic setRd(input int k, input logic [AW-1:0] a);
        rdAddr[k*AW +: AW] = a;
    endtask

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        rdAddr = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkVal("rst_log_vld",  logVldA,  2'b00);
        checkVal("rst_log_addr", logAddrA, '0);
        checkVal("rst_log_data", logDataA, '0);
        checkVal("rst_rd_busy",  rdBusyA,  4'h0);
        setRd(0, 5'd3);
        #1;
        checkVal("rst_rd3", rdDataA[31:0], 32'h0);

        // Write port 0 to r3 with same-cycle bypass, then commit log
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h11111111;
        #1;
        checkVal("byp_w0_r3", rdDataA[31:0], 32'h11111111);
        tick();
        idle();
        #1;
        checkVal("log_vld_w0",  logVldA,        2'b01);
        checkVal("log_addr_w0", logAddrA[4:0],  5'd3);
        checkVal("log_data_w0", logDataA[31:0], 32'h11111111);
        checkVal("stored_r3",   rdDataA[31:0],  32'h11111111);
        tick();
        checkVal("log_vld_pulse", logVldA, 2'b00);

        // Both ports write r7: port 1 wins for bypass, storage and log
        setRd(1, 5'd7);
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hAAAA0000;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h5555FFFF;
        #1;
        checkVal("byp_coll_r7", rdDataA[63:32], 32'h5555FFFF);
        tick();
        idle();
        #1;
        checkVal("log_vld_coll",  logVldA,         2'b10);
        checkVal("log_addr_coll", logAddrA[9:5],   5'd7);
        checkVal("log_data_coll", logDataA[63:32], 32'h5555FFFF);
        checkVal("stored_r7",     rdDataA[63:32],  32'h5555FFFF);

        // Write to r0: hardwired zero in dutA, ordinary register in dutB
        setRd(0, 5'd0);
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hDEADBEEF;
        #1;
        checkVal("r0_byp_zero", rdDataA[31:0], 32'h0);
        checkVal("r0_byp_norm", rdDataB[31:0], 32'hDEADBEEF);
        tick();
        idle();
        #1;
        checkVal("r0_log_zero",  logVldA,         2'b00);
        checkVal("r0_log_norm",  logVldB,         2'b10);
        checkVal("r0_logd_norm", logDataB[63:32], 32'hDEADBEEF);
        checkVal("r0_rd_zero",   rdDataA[31:0],   32'h0);
        checkVal("r0_rd_norm",   rdDataB[31:0],   32'hDEADBEEF);

        // Scoreboard on r9
        setRd(0, 5'd9);
        issEn = 1'b1; issAddr = 5'd9;
        #1;
        checkVal("iss_same_cyc", rdBusyA[0], 1'b0);
        tick();
        idle();
        #1;
        checkVal("iss_busy", rdBusyA[0], 1'b1);
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h00000099;
        #1;
        checkVal("wr_mask_busy", rdBusyA[0],    1'b0);
        checkVal("wr_byp_r9",    rdDataA[31:0], 32'h00000099);
        tick();
        idle();
        #1;
        checkVal("wr_clear", rdBusyA[0], 1'b0);
        issEn = 1'b1; issAddr = 5'd9;
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h0000009A;
        tick();
        idle();
        #1;
        checkVal("iss_wr_same", rdBusyA[0], 1'b1);
        issEn = 1'b1; issAddr = 5'd9;
        tick();
        idle();
        #1;
        checkVal("iss_rebusy", rdBusyA[0], 1'b1);
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h0000009B;
        tick();
        idle();

        // Issue to r0: ignored when hardwired, tracked otherwise
        setRd(0, 5'd0);
        issEn = 1'b1; issAddr = 5'd0;
        tick();
        idle();
        #1;
        checkVal("iss_r0_zero", rdBusyA[0], 1'b0);
        checkVal("iss_r0_norm", rdBusyB[0], 1'b1);

        // Four ports on r12 while port 0 writes it
        for (int k = 0; k < 4; k++) setRd(k, 5'd12);
        issEn = 1'b1; issAddr = 5'd12;
        tick();
        idle();
        #1;
        checkVal("r12_busy_all", rdBusyA, 4'hF);
        we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'hC0FFEE12;
        #1;
        checkVal("r12_byp_all",  rdDataA, {4{32'hC0FFEE12}});
        checkVal("r12_busy_off", rdBusyA, 4'h0);
        tick();
        idle();

        // Reset cycle with a write to r5 and an issue to r6
        setRd(0, 5'd5); setRd(1, 5'd3); setRd(2, 5'd6);
        reset = 1'b1;
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h00000055;
        issEn = 1'b1; issAddr = 5'd6;
        #1;
        checkVal("rst_byp_r5",  rdDataA[31:0],  32'h00000055);
        checkVal("rst_pre_r3",  rdDataA[63:32], 32'h11111111);
        tick();
        reset = 1'b0;
        idle();
        #1;
        checkVal("post_rst_r5",   rdDataA[31:0],  32'h0);
        checkVal("post_rst_r3",   rdDataA[63:32], 32'h0);
        checkVal("post_rst_busy", rdBusyA[2],     1'b0);
        checkVal("post_rst_log",  logVldA,        2'b00);
        checkVal("post_rst_logB", logVldB,        2'b00);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; depth = 2**ADDR_W.
REQ-003 Parameter NRP, default 2: number of read ports, 1..4.
REQ-004 Parameter ZERO_R0, default 1: when 1, register 0 reads zero and ignores writes.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 rd_addr  in  NRP*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-008 rd_data  out  NRP*DATA_W  read data, packed the same way.
REQ-009 rd_busy  out  NRP  scoreboard busy bit of each read address.
REQ-010 we0 / waddr0 / wdata0  in  1 / ADDR_W / DATA_W  write port 0.
REQ-011 we1 / waddr1 / wdata1  in  1 / ADDR_W / DATA_W  write port 1; higher priority.
REQ-012 iss_en / iss_addr  in  1 / ADDR_W  marks a register as pending a future write.
REQ-013 log_vld  out  2  per-write-port commit-log valid, registered.
REQ-014 log_addr / log_data  out  2*ADDR_W / 2*DATA_W  commit-log address and data, per write port.

Function
REQ-015 Reads are combinational; rd_data[k] = register at rd_addr[k], except as REQ-016..018.
REQ-016 Write-through bypass: same-cycle effective write to rd_addr[k] drives rd_data[k] with that write's data.
REQ-017 Both ports writing one address: port 1 data wins for storage and bypass; port 0 write to it is dropped.
REQ-018 ZERO_R0=1: rd_data for address 0 is 0; writes to 0 neither stored nor bypassed nor logged; iss_en to 0 ignored.
REQ-019 Effective write = weN high and (ZERO_R0=0 or waddrN != 0), minus REQ-017 drop; stored on next rising edge.
REQ-020 Scoreboard: one busy bit per register; iss_en sets busy[iss_addr] at next edge.
REQ-021 An effective write clears busy[waddr] at next edge.
REQ-022 iss_en and effective write to the same address in one cycle: busy ends set (new producer wins).
REQ-023 iss_en to an already-busy register: legal, busy remains set.
REQ-024 rd_busy[k] = busy[rd_addr[k]] AND NOT (same-cycle effective write to rd_addr[k]); iss_en does not affect rd_busy in its own cycle.
REQ-025 Commit log: each effective write asserts log_vld[n] for exactly one cycle, one cycle after the write, with registered address and data.
REQ-026 Dropped port-0 write (REQ-017) yields log_vld[0]=0.
REQ-027 All read-port logic is independent; any number of ports may share an address.

Reset
REQ-028 reset high at a rising edge: all registers 0, all busy bits 0, log_vld 0, log_addr 0, log_data 0.
REQ-029 Writes and issues in a reset cycle are discarded; no log entry results.
REQ-030 During reset, rd_data and rd_busy follow REQ-015..024 against pre-reset state; bypass still applies.

Structure
REQ-031 Shared package holds default DATA_W, ADDR_W, NRP and a write-port index enum (WP0, WP1).
REQ-032 Sub-module reg_scoreboard holds busy bits and REQ-020..024 logic; storage, bypass and log stay in reg_file_mp.
REQ-033 Storage is a flop array; no vendor RAM inference.

Verification
REQ-034 After reset, write we0 addr 3 data 0x11111111 and read port 0 addr 3 in the same cycle -> rd_data 0x11111111; next cycle log_vld=01, log_addr[0]=3.
REQ-035 we0 and we1 both addr 7 (0xAAAA0000 / 0x5555FFFF) -> stored and bypassed 0x5555FFFF; log_vld=10.
REQ-036 ZERO_R0=1, we1 addr 0 data 0xDEADBEEF -> rd_data addr 0 = 0, log_vld=00; repeat with ZERO_R0=0 -> stored and logged.
REQ-037 iss_en addr 9; next cycle rd_busy=1; write addr 9 -> rd_busy 0 that cycle; next cycle busy clear; iss+write addr 9 same cycle -> busy 1 after.
REQ-038 NRP=4, all ports addr 12 while we0 writes 12 -> all four rd_data equal write data, all rd_busy 0.
REQ-039 Write addr 5 and iss addr 6 in a reset cycle -> after reset, register 5 reads 0, busy[6]=0, log_vld=00.
